mips_rst_seq: RTL and testbench



---
 rtl/mips_rst_seq.sv | 188 ++++++++++++++++++
 tb/tb_mips_rst_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_rst_seq.sv
// mips_rst_seq
//   Reset sequencer and watchdog for the MIPS core and its peripherals.
//   The board-level cpu_rst is synchronised for deassertion, stretched,
//   and then CHANNELS reset domains are released one after another,
//   bit 0 first. Once every domain is released (RUN), a software
//   request or a watchdog timeout re-runs the full sequence, and the
//   cause of the most recent reset is recorded.
//
// Ports
//   cpu_clk     : system clock, rising edge
//   cpu_rst     : asynchronous active-high board reset
//   sw_rst_req  : software reset request (acted on in RUN only)
//   wdt_en      : watchdog enable
//   wdt_kick    : watchdog service strobe
//   wdt_limit   : watchdog timeout threshold, 0 disables the watchdog
//   rst_out     : active-high resets, one per domain
//   rst_done    : high in RUN (every domain released)
//   rst_cause   : 00 external, 01 software, 10 watchdog
//   wdt_count   : current watchdog count
//   state_dbg   : FSM state (0 ASSERT, 1 RELEASE, 2 RUN)
//
// Handshakes: this block has no valid/ready interfaces; sw_rst_req and
// wdt_kick are level samples taken at each rising edge of cpu_clk.
module mips_rst_seq #(
  parameter int CHANNELS    = 4,
  parameter int STRETCH     = 16,
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_W       = 16
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                sw_rst_req,
  input  logic                wdt_en,
  input  logic                wdt_kick,
  input  logic [WDT_W-1:0]    wdt_limit,
  output logic [CHANNELS-1:0] rst_out,
  output logic                rst_done,
  output logic [1:0]          rst_cause,
  output logic [WDT_W-1:0]    wdt_count,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // One counter serves both the stretch and the inter-channel gap.
  localparam int CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CHANNELS-1:0]  rst_out_n;
  logic                 rst_done_n;
  logic [1:0]           rst_cause_n;
  logic [WDT_W-1:0]     wdt_count_n;
  logic [CHANNELS-1:0]  rst_shift;
  logic                 wdt_run;

  // Deassertion synchroniser: set asynchronously, drains to 0.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srst;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign srst = sync_q[SYNC_STAGES-1];

  // Releasing a channel shifts the lowest asserted bit out, so the
  // vector walks 1111 -> 1110 -> 1100 -> 1000 -> 0000.
  assign rst_shift = rst_out << 1;
  assign wdt_run   = wdt_en && (wdt_limit != '0);
  assign state_dbg = state;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_EXT;
      wdt_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rst_out   <= rst_out_n;
      rst_done  <= rst_done_n;
      rst_cause <= rst_cause_n;
      wdt_count <= wdt_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rst_out_n   = rst_out;
    rst_done_n  = rst_done;
    rst_cause_n = rst_cause;
    wdt_count_n = wdt_count;

    case (state)
      ST_ASSERT: begin
        rst_out_n   = '1;
        rst_done_n  = 1'b0;
        wdt_count_n = '0;
        if (srst) begin
          cnt_n = '0;
        end else if (cnt == STRETCH_LAST) begin
          // Entering RELEASE already frees channel 0.
          rst_out_n = rst_shift;
          cnt_n     = '0;
          if (rst_shift == '0) begin
            state_n    = ST_RUN;
            rst_done_n = 1'b1;
          end else begin
            state_n = ST_RELEASE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        wdt_count_n = '0;
        if (cnt == GAP_LAST) begin
          rst_out_n = rst_shift;
          cnt_n     = '0;
          if (rst_shift == '0) begin
            state_n    = ST_RUN;
            rst_done_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        rst_out_n  = '0;
        rst_done_n = 1'b1;
        cnt_n      = '0;
        if (sw_rst_req) begin
          // Software request wins over a coincident watchdog timeout.
          state_n     = ST_ASSERT;
          rst_out_n   = '1;
          rst_done_n  = 1'b0;
          rst_cause_n = CAUSE_SW;
          wdt_count_n = '0;
        end else if (wdt_run) begin
          if (wdt_kick) begin
            wdt_count_n = '0;
          end else if (wdt_count == wdt_limit) begin
            state_n     = ST_ASSERT;
            rst_out_n   = '1;
            rst_done_n  = 1'b0;
            rst_cause_n = CAUSE_WDT;
            wdt_count_n = '0;
          end else begin
            // Live compare: a limit lowered below the count is only
            // reached again after the counter wraps.
            wdt_count_n = wdt_count + WDT_W'(1);
          end
        end else begin
          wdt_count_n = '0;
        end
      end

      default: begin
        state_n     = ST_ASSERT;
        cnt_n       = '0;
        rst_out_n   = '1;
        rst_done_n  = 1'b0;
        wdt_count_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_rst_seq.sv
// tb_mips_rst_seq
//   Directed bench for mips_rst_seq. Instance u_dut uses the default
//   parameters; u_min uses CHANNELS=1, STRETCH=1, GAP=1.
//   Edge numbering after a cpu_rst release: edge 1 is the first rising
//   edge after the release, T0 is edge 2 (SYNC_STAGES), so with the
//   defaults the channels fall at edges 18/22/26/30 and rst_done rises
//   at edge 30. For a software/watchdog reset at edge S the channels
//   fall at S+16/20/24/28.
module tb_mips_rst_seq;

  logic        clk;
  logic        cpu_rst;
  logic        sw_rst_req;
  logic        wdt_en;
  logic        wdt_kick;
  logic [15:0] wdt_limit;
  logic [3:0]  rst_out;
  logic        rst_done;
  logic [1:0]  rst_cause;
  logic [15:0] wdt_count;
  logic [1:0]  state_dbg;

  logic        rst_b;
  logic        sw_b;
  logic        en_b;
  logic        kick_b;
  logic [15:0] limit_b;
  logic [0:0]  b_rst_out;
  logic        b_done;
  logic [1:0]  b_cause;
  logic [15:0] b_wdt;
  logic [1:0]  b_state;

  int n_cmp;
  int n_bad;

  mips_rst_seq u_dut (
    .cpu_clk   (clk),
    .cpu_rst   (cpu_rst),
    .sw_rst_req(sw_rst_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .wdt_limit (wdt_limit),
    .rst_out   (rst_out),
    .rst_done  (rst_done),
    .rst_cause (rst_cause),
    .wdt_count (wdt_count),
    .state_dbg (state_dbg)
  );

  mips_rst_seq #(.CHANNELS(1), .STRETCH(1), .GAP(1)) u_min (
    .cpu_clk   (clk),
    .cpu_rst   (rst_b),
    .sw_rst_req(sw_b),
    .wdt_en    (en_b),
    .wdt_kick  (kick_b),
    .wdt_limit (limit_b),
    .rst_out   (b_rst_out),
    .rst_done  (b_done),
    .rst_cause (b_cause),
    .wdt_count (b_wdt),
    .state_dbg (b_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cpu_rst    = 1'b1;
    sw_rst_req = 1'b0;
    wdt_en     = 1'b0;
    wdt_kick   = 1'b0;
    wdt_limit  = 16'd0;
    rst_b      = 1'b1;
    sw_b       = 1'b0;
    en_b       = 1'b0;
    kick_b     = 1'b0;
    limit_b    = 16'd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (rst_out !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_async_out: got %b want 1111", rst_out);
    end
    n_cmp++;
    if (rst_done !== 1'b0 || rst_cause !== 2'b00 || wdt_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_async_flags: got done=%b cause=%b wdt=%0d want 0/00/0",
               rst_done, rst_cause, wdt_count);
    end
    repeat (5) tick();
    n_cmp++;
    if (rst_out !== 4'b1111 || rst_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got out=%b done=%b want 1111/0", rst_out, rst_done);
    end
  endtask

  // Release cpu_rst and follow the whole sequence edge by edge.
  task automatic run_por_sequence(input string tag);
    logic [3:0] exp_out;
    logic       exp_done;
    @(negedge clk);
    cpu_rst = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_out[k] = (e < 18 + 4 * k);
      exp_done = (e >= 30);
      n_cmp++;
      if (rst_out !== exp_out) begin
        n_bad++;
        $display("FAIL %s_out edge %0d: got %b want %b", tag, e, rst_out, exp_out);
      end
      n_cmp++;
      if (rst_done !== exp_done) begin
        n_bad++;
        $display("FAIL %s_done edge %0d: got %b want %b", tag, e, rst_done, exp_done);
      end
    end
    n_cmp++;
    if (rst_cause !== 2'b00 || state_dbg !== 2'd2) begin
      n_bad++;
      $display("FAIL %s_cause_state: got cause=%b state=%0d want 00/2", tag, rst_cause, state_dbg);
    end
  endtask

  task automatic test_power_on();
    run_por_sequence("por");
  endtask

  task automatic test_sw_reset();
    logic [3:0] exp_out;
    sw_rst_req = 1'b1;
    tick();                       // edge S
    sw_rst_req = 1'b0;
    n_cmp++;
    if (rst_out !== 4'b1111 || rst_done !== 1'b0 || rst_cause !== 2'b01) begin
      n_bad++;
      $display("FAIL sw_entry: got out=%b done=%b cause=%b want 1111/0/01",
               rst_out, rst_done, rst_cause);
    end
    for (int e = 1; e <= 28; e++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_out[k] = (e < 16 + 4 * k);
      n_cmp++;
      if (rst_out !== exp_out || rst_done !== (e >= 28)) begin
        n_bad++;
        $display("FAIL sw_seq edge S+%0d: got out=%b done=%b want %b/%b",
                 e, rst_out, rst_done, exp_out, (e >= 28));
      end
      // Second request lands on edge S+18, inside RELEASE: ignored.
      if (e == 17) sw_rst_req = 1'b1;
      if (e == 18) sw_rst_req = 1'b0;
    end
    n_cmp++;
    if (rst_cause !== 2'b01) begin
      n_bad++;
      $display("FAIL sw_cause: got %b want 01", rst_cause);
    end
  endtask

  task automatic test_watchdog();
    logic [15:0] exp_cnt;
    int          drops;
    int          cnt_bad;
    wdt_en    = 1'b1;
    wdt_limit = 16'd100;
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 1 || i == 50 || i == 100) begin
        n_cmp++;
        if (wdt_count !== 16'(i) || rst_done !== 1'b1) begin
          n_bad++;
          $display("FAIL wdt_count R+%0d: got cnt=%0d done=%b want %0d/1", i, wdt_count, rst_done, i);
        end
      end
    end
    n_cmp++;
    if (rst_out !== 4'b1111 || rst_done !== 1'b0 || rst_cause !== 2'b10 || wdt_count !== 16'd0) begin
      n_bad++;
      $display("FAIL wdt_trigger: got out=%b done=%b cause=%b cnt=%0d want 1111/0/10/0",
               rst_out, rst_done, rst_cause, wdt_count);
    end
    repeat (28) tick();
    n_cmp++;
    if (rst_done !== 1'b1 || rst_out !== 4'b0000 || rst_cause !== 2'b10) begin
      n_bad++;
      $display("FAIL wdt_rerun: got done=%b out=%b cause=%b want 1/0000/10", rst_done, rst_out, rst_cause);
    end

    // Kick every 50 cycles for 2000 cycles: count never reaches 100.
    exp_cnt = 16'd0;
    drops   = 0;
    cnt_bad = 0;
    for (int i = 1; i <= 2000; i++) begin
      wdt_kick = (i % 50 == 0);
      tick();
      exp_cnt = wdt_kick ? 16'd0 : exp_cnt + 16'd1;
      if (rst_done !== 1'b1) drops++;
      if (wdt_count !== exp_cnt) cnt_bad++;
    end
    wdt_kick = 1'b0;
    n_cmp++;
    if (drops !== 0) begin
      n_bad++;
      $display("FAIL kick_no_reset: got %0d reset cycles want 0", drops);
    end
    n_cmp++;
    if (cnt_bad !== 0) begin
      n_bad++;
      $display("FAIL kick_count: got %0d count errors want 0", cnt_bad);
    end

    // Kick coincident with count==limit: no reset.
    repeat (100) tick();
    n_cmp++;
    if (wdt_count !== 16'd100) begin
      n_bad++;
      $display("FAIL kick_edge_pre: got %0d want 100", wdt_count);
    end
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    n_cmp++;
    if (wdt_count !== 16'd0 || rst_done !== 1'b1 || rst_out !== 4'b0000) begin
      n_bad++;
      $display("FAIL kick_edge: got cnt=%0d done=%b out=%b want 0/1/0000", wdt_count, rst_done, rst_out);
    end
    tick();
    n_cmp++;
    if (wdt_count !== 16'd1) begin
      n_bad++;
      $display("FAIL kick_edge_post: got %0d want 1", wdt_count);
    end
  endtask

  task automatic test_simultaneous();
    int bad;
    // Count is 1 now; it reaches 100 in 99 edges, the next is the timeout.
    repeat (99) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_cmp++;
    if (rst_cause !== 2'b01 || rst_out !== 4'b1111 || rst_done !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_vs_wdt: got cause=%b out=%b done=%b want 01/1111/0",
               rst_cause, rst_out, rst_done);
    end
    repeat (28) tick();
    n_cmp++;
    if (rst_done !== 1'b1) begin
      n_bad++;
      $display("FAIL sw_vs_wdt_rerun: got done=%b want 1", rst_done);
    end

    wdt_en    = 1'b1;
    wdt_limit = 16'd0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (wdt_count !== 16'd0 || rst_done !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL wdt_limit0: got %0d bad cycles want 0", bad);
    end

    wdt_en    = 1'b0;
    wdt_limit = 16'd100;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (wdt_count !== 16'd0 || rst_done !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL wdt_disabled: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_async_mid();
    sw_rst_req = 1'b1;
    tick();                       // edge S
    sw_rst_req = 1'b0;
    repeat (21) tick();           // between release of bit 1 (S+20) and bit 2 (S+24)
    n_cmp++;
    if (rst_out !== 4'b1100) begin
      n_bad++;
      $display("FAIL mid_pre: got %b want 1100", rst_out);
    end
    #2;
    cpu_rst = 1'b1;
    #1;
    n_cmp++;
    if (rst_out !== 4'b1111 || rst_done !== 1'b0 || rst_cause !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_async: got out=%b done=%b cause=%b want 1111/0/00",
               rst_out, rst_done, rst_cause);
    end
    repeat (3) tick();
    run_por_sequence("rerun");
  endtask

  task automatic test_param_sweep();
    n_cmp++;
    if (b_rst_out !== 1'b1 || b_done !== 1'b0) begin
      n_bad++;
      $display("FAIL min_reset: got out=%b done=%b want 1/0", b_rst_out, b_done);
    end
    @(negedge clk);
    rst_b = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp++;
      if (b_rst_out !== 1'(e < 3) || b_done !== (e >= 3)) begin
        n_bad++;
        $display("FAIL min_seq edge %0d: got out=%b done=%b want %b/%b",
                 e, b_rst_out, b_done, (e < 3), (e >= 3));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_power_on();
    test_sw_reset();
    test_watchdog();
    test_simultaneous();
    test_async_mid();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
